nibble_invert_arbiter: RTL and testbench
========================================

// Module: nibble_invert_arbiter
// PURPOSE
//  Shares the 4-bit nibble-inversion datapath between two requesters (A, B).
//  Round-robin arbiter grants one nibble per cycle, applies optional per-source
//  inversion at accept time, and buffers results in a small FIFO drained by a
//  valid/ready consumer. Sits between ui_in-side producers and uo_out.
// PARAMETERS
//  DEPTH  2  FIFO entries; power of two, >= 2
//  CNT_W  8  width of per-source saturating grant counters
// PORTS
//  clk          in   1      clock, all state on rising edge
//  rst          in   1      asynchronous, active-high reset
//  a_valid      in   1      requester A has a nibble
//  a_data       in   4      requester A nibble
//  a_ready      out  1      A nibble accepted this cycle (a_valid & a_ready)
//  inv_en_a     in   1      1: invert A nibble; 0: pass through
//  b_valid      in   1      requester B has a nibble
//  b_data       in   4      requester B nibble
//  b_ready      out  1      B nibble accepted this cycle
//  inv_en_b     in   1      1: invert B nibble; 0: pass through
//  out_valid    out  1      FIFO head valid
//  out_data     out  4      FIFO head nibble (post-inversion)
//  out_src      out  1      FIFO head source: 0=A, 1=B
//  out_ready    in   1      consumer takes head when out_valid & out_ready
//  grant_cnt_a  out  CNT_W  accepted-A count, saturating
//  grant_cnt_b  out  CNT_W  accepted-B count, saturating
// BEHAVIOUR
//  Reset (async, immediate): FIFO count=0, rd/wr ptrs=0, out_valid=0,
//   out_data=0, out_src=0, grant counters=0, last_grant=B (A wins first tie).
//  Full = (count==DEPTH), evaluated on registered count at cycle start;
//   no push-on-pop when full (ready low while full even if out_ready=1).
//  Arbitration (combinational, when !full):
//   only A valid -> grant A; only B valid -> grant B;
//   both valid -> grant source != last_grant; none -> no grant.
//  a_ready = grant_A; b_ready = grant_B; never both high; both 0 when full.
//  Readiness does not depend on out_ready (no comb path out_ready->x_ready).
//  On grant: write {src, data ^ {4{inv_en_src}}} at wr_ptr; inv_en sampled in
//   the accept cycle only; later changes do not affect stored entries.
//   last_grant <= granted source; counter of that source += 1, holds at max.
//  Pop: out_valid & out_ready -> rd_ptr += 1.
//  Pointers wrap modulo DEPTH. Simultaneous push and pop: count unchanged.
//  out_valid = (count!=0); out_data/out_src = entry at rd_ptr (comb read of
//   registered storage); when empty out_data/out_src are don't-care, bench
//   checks only while out_valid=1.
//  Latency: nibble accepted in cycle N appears at out in cycle N+1 if FIFO
//   empty; otherwise strict FIFO order behind older entries.
//  Throughput: 1 nibble/cycle sustained with out_ready=1.
//  Reset mid-operation: all buffered entries discarded, no output glitch
//   beyond out_valid dropping to 0 asynchronously.
// TESTING
//  1 A only, a_data=4'h3, inv_en_a=1, out_ready=1 -> next cycle out_valid=1,
//    out_data=4'hC, out_src=0; grant_cnt_a=1.
//  2 A and B held valid, a_data=4'h1, b_data=4'h2, inv_en=0, out_ready=1 ->
//    grants A,B,A,B...; out sequence 1/src0,2/src1 alternating, 1 per cycle.
//  3 out_ready=0, both valid, DEPTH=2 -> two accepts (A then B), then
//    a_ready=b_ready=0; raise out_ready -> pops A entry, then ready returns.
//  4 CNT_W=2, A valid for 5 accepts -> grant_cnt_a reads 1,2,3,3,3.
//  5 Toggle inv_en_a after accepting a_data=4'h5 with inv_en_a=0 -> stored
//    and output out_data=4'h5 (not 4'hA).
//  6 FIFO holding 2 entries, assert rst mid-cycle -> out_valid=0 at once,
//    counters 0; after release, first tie grants A.

Source files
------------

// File: rtl/nibble_invert_arbiter_if.sv
// Handshake bundle between the two nibble producers, the arbiter and the consumer.
// Every channel moves a transfer on a cycle where valid and ready are both high at the clock edge.
interface nibble_invert_arbiter_if;
  logic       a_valid;
  logic [3:0] a_data;
  logic       a_ready;
  logic       inv_en_a;
  logic       b_valid;
  logic [3:0] b_data;
  logic       b_ready;
  logic       inv_en_b;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_src;
  logic       out_ready;

  modport slave (
    input  a_valid, a_data, inv_en_a, b_valid, b_data, inv_en_b, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_src
  );

  modport master (
    output a_valid, a_data, inv_en_a, b_valid, b_data, inv_en_b, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/nibble_invert_arbiter.sv
// Round-robin arbiter sharing one nibble-inversion path between sources A and B,
// buffering inverted results in a DEPTH-entry FIFO with saturating grant counters.
module nibble_invert_arbiter #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  nibble_invert_arbiter_if.slave   bus,
  output logic [CNT_W-1:0]         grant_cnt_a,
  output logic [CNT_W-1:0]         grant_cnt_b
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_F = $clog2(DEPTH + 1);

  logic [3:0]       mem_data [DEPTH];
  logic             mem_src  [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_F-1:0] count;
  logic             last_grant_b;

  logic       full;
  logic       grant_a;
  logic       grant_b;
  logic       push;
  logic       pop;
  logic [3:0] wr_data;

  // Readiness depends only on registered count and the requesters, never on out_ready.
  always_comb begin
    full    = (count == CNT_F'(DEPTH));
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!full) begin
      if (bus.a_valid && bus.b_valid) begin
        grant_a = last_grant_b;
        grant_b = !last_grant_b;
      end else begin
        grant_a = bus.a_valid;
        grant_b = bus.b_valid;
      end
    end
    push    = grant_a || grant_b;
    wr_data = grant_a ? (bus.a_data ^ {4{bus.inv_en_a}})
                      : (bus.b_data ^ {4{bus.inv_en_b}});
    pop     = bus.out_valid && bus.out_ready;
  end

  assign bus.a_ready   = grant_a;
  assign bus.b_ready   = grant_b;
  assign bus.out_valid = (count != '0);
  assign bus.out_data  = mem_data[rd_ptr];
  assign bus.out_src   = mem_src[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_src[i]  <= 1'b0;
      end
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      last_grant_b <= 1'b1;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= wr_data;
        mem_src[wr_ptr]  <= grant_b;
        wr_ptr           <= wr_ptr + 1'b1;
        last_grant_b     <= grant_b;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt_a <= '0;
      grant_cnt_b <= '0;
    end else begin
      if (grant_a && (grant_cnt_a != '1)) grant_cnt_a <= grant_cnt_a + 1'b1;
      if (grant_b && (grant_cnt_b != '1)) grant_cnt_b <= grant_cnt_b + 1'b1;
    end
  end
endmodule

// File: tb/tb_nibble_invert_arbiter.sv
// Scoreboard bench: a reference model predicts grants and FIFO contents each cycle.
module tb_nibble_invert_arbiter;
  localparam int DEPTH = 2;
  localparam int CNT_W = 2;
  localparam int W     = 5;

  logic clk;
  logic rst;
  logic [CNT_W-1:0] grant_cnt_a;
  logic [CNT_W-1:0] grant_cnt_b;

  nibble_invert_arbiter_if bus ();

  nibble_invert_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .grant_cnt_a (grant_cnt_a),
    .grant_cnt_b (grant_cnt_b)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state
  logic [W-1:0] exp_q[$];
  int  m_cnt_a;
  int  m_cnt_b;
  logic m_last_b;
  int  n_checks;
  int  n_errors;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [3:0] ad, input logic ia,
                       input logic bv, input logic [3:0] bd, input logic ib,
                       input logic ordy);
    bus.a_valid   = av;
    bus.a_data    = ad;
    bus.inv_en_a  = ia;
    bus.b_valid   = bv;
    bus.b_data    = bd;
    bus.inv_en_b  = ib;
    bus.out_ready = ordy;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt_a  = 0;
    m_cnt_b  = 0;
    m_last_b = 1'b1;
  endtask

  // Check everything at the negedge, update the model, then advance past the posedge.
  task automatic cycle();
    logic full, ga, gb, ov;
    logic [W-1:0] head;
    @(negedge clk);
    full = (exp_q.size() == DEPTH);
    ga = 1'b0;
    gb = 1'b0;
    if (!full) begin
      if (bus.a_valid && bus.b_valid) begin
        ga = m_last_b;
        gb = !m_last_b;
      end else begin
        ga = bus.a_valid;
        gb = bus.b_valid;
      end
    end
    ov = (exp_q.size() != 0);
    check("a_ready", 8'(bus.a_ready), 8'(ga));
    check("b_ready", 8'(bus.b_ready), 8'(gb));
    check("out_valid", 8'(bus.out_valid), 8'(ov));
    check("grant_cnt_a", 8'(grant_cnt_a), 8'(m_cnt_a));
    check("grant_cnt_b", 8'(grant_cnt_b), 8'(m_cnt_b));
    if (ov && bus.out_valid) begin
      head = exp_q[0];
      check("out_data", 8'(bus.out_data), 8'(head[3:0]));
      check("out_src", 8'(bus.out_src), 8'(head[4]));
    end
    if (ov && bus.out_ready) void'(exp_q.pop_front());
    if (ga) begin
      exp_q.push_back({1'b0, bus.a_data ^ {4{bus.inv_en_a}}});
      m_last_b = 1'b0;
      if (m_cnt_a < 3) m_cnt_a++;
    end
    if (gb) begin
      exp_q.push_back({1'b1, bus.b_data ^ {4{bus.inv_en_b}}});
      m_last_b = 1'b1;
      if (m_cnt_b < 3) m_cnt_b++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 8'(bus.out_valid), 8'h0);
    check("rst_out_data", 8'(bus.out_data), 8'h0);
    check("rst_out_src", 8'(bus.out_src), 8'h0);
    check("rst_cnt_a", 8'(grant_cnt_a), 8'h0);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    drive(0, 4'h0, 0, 0, 4'h0, 0, 0);
    do_reset();

    // A only with inversion: 3 -> C one cycle later
    drive(1, 4'h3, 1, 0, 4'h0, 0, 1);
    cycle();
    drive(0, 4'h0, 0, 0, 4'h0, 0, 1);
    cycle();
    check("t1_cnt_a", 8'(grant_cnt_a), 8'h1);

    // both held valid: strict alternation A,B,A,B
    drive(1, 4'h1, 0, 1, 4'h2, 0, 1);
    repeat (8) cycle();
    drive(0, 4'h0, 0, 0, 4'h0, 0, 1);
    repeat (2) cycle();

    // backpressure: fill, stall, then drain one
    drive(1, 4'h6, 0, 1, 4'h9, 1, 0);
    repeat (4) cycle();
    check("t3_full_a_ready", 8'(bus.a_ready), 8'h0);
    drive(1, 4'h6, 0, 1, 4'h9, 1, 1);
    repeat (4) cycle();
    drive(0, 4'h0, 0, 0, 4'h0, 0, 1);
    repeat (3) cycle();

    // inv_en sampled only at accept time
    drive(1, 4'h5, 0, 0, 4'h0, 0, 0);
    cycle();
    drive(0, 4'h5, 1, 0, 4'h0, 0, 0);
    repeat (2) cycle();
    check("t5_held_data", 8'(bus.out_data), 8'h5);
    drive(0, 4'h0, 1, 0, 4'h0, 0, 1);
    repeat (2) cycle();

    // saturation of the 2-bit counter (A already saturated; check B too)
    drive(0, 4'h0, 0, 1, 4'h7, 0, 1);
    repeat (5) cycle();
    check("t4_cnt_b_sat", 8'(grant_cnt_b), 8'h3);
    drive(0, 4'h0, 0, 0, 4'h0, 0, 1);
    cycle();

    // random traffic
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0));
      cycle();
    end

    // reset mid-cycle with a full FIFO
    drive(1, 4'hA, 0, 1, 4'hB, 0, 0);
    repeat (3) cycle();
    check("t6_pre_valid", 8'(bus.out_valid), 8'h1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_valid", 8'(bus.out_valid), 8'h0);
    check("t6_async_cnt_a", 8'(grant_cnt_a), 8'h0);
    check("t6_async_cnt_b", 8'(grant_cnt_b), 8'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1, 4'hA, 0, 1, 4'hB, 0, 1);
    check("t6_tie_a_first", 8'(bus.a_ready), 8'h1);
    repeat (4) cycle();
    drive(0, 4'h0, 0, 0, 4'h0, 0, 1);
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
